// File: rtl/addr_link_arbiter_pkg.sv
// addr_link_arbiter_pkg: shared state encoding, link geometry defaults and helpers for the address-link arbiter.
package addr_link_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_SEND, ARB_GAP} arb_state_t;
  localparam int MEM_ADDR_SIZE = 32;
  localparam int BANDWIDTH_WRITE_ADDRESS = 8;
  localparam int DEF_TIMEOUT_SLACK = 4;
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/addr_link_arbiter_if.sv
// addr_link_arbiter_if: requester and address-sender signals of the shared write-address link.
interface addr_link_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W = 32
);
  localparam int GID_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*ADDR_W-1:0] addr_in;
  logic [NUM_REQ-1:0] ack;
  logic err;
  logic busy;
  logic [GID_W-1:0] grant_id;
  logic snd_send;
  logic [ADDR_W-1:0] snd_addr;
  logic snd_done;
  modport slave (input req, addr_in, snd_done, output ack, err, busy, grant_id, snd_send, snd_addr);
  modport master (output req, addr_in, snd_done, input ack, err, busy, grant_id, snd_send, snd_addr);
endinterface

// File: rtl/addr_link_arbiter_rr_pick.sv
// addr_link_arbiter_rr_pick: combinational round-robin picker, first set request after ptr with wrap.
module addr_link_arbiter_rr_pick #(
  parameter int N = 4,
  parameter int GID_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [GID_W-1:0] ptr,
  output logic             valid,
  output logic [GID_W-1:0] winner
);
  // Scan farthest to nearest so the closest candidate after ptr overwrites the rest.
  always_comb begin
    valid = |req;
    winner = ptr;
    for (int k = N; k >= 1; k--)
      if (req[(int'(ptr) + k) % N]) winner = GID_W'((int'(ptr) + k) % N);
  end
endmodule

// File: rtl/addr_link_arbiter.sv
// addr_link_arbiter: round-robin owner of the serial write-address link with send gap and done watchdog.
module addr_link_arbiter
  import addr_link_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W = MEM_ADDR_SIZE,
  parameter int BUS_W = BANDWIDTH_WRITE_ADDRESS,
  parameter int TIMEOUT_SLACK = DEF_TIMEOUT_SLACK
) (
  input logic clk,
  input logic reset,
  addr_link_arbiter_if.slave bus
);
  localparam int BEATS = ceil_div(ADDR_W, BUS_W);
  localparam int TIMEOUT = BEATS + 1 + TIMEOUT_SLACK;
  localparam int GID_W = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  arb_state_t state;
  logic [GID_W-1:0] ptr;
  logic [GID_W-1:0] winner;
  logic valid;
  logic [TW-1:0] timer;
  addr_link_arbiter_rr_pick #(.N(NUM_REQ), .GID_W(GID_W)) u_pick (
    .req(bus.req),
    .ptr(ptr),
    .valid(valid),
    .winner(winner)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ARB_IDLE;
      ptr <= GID_W'(NUM_REQ - 1);
      timer <= '0;
      bus.ack <= '0;
      bus.err <= 1'b0;
      bus.busy <= 1'b0;
      bus.snd_send <= 1'b0;
      bus.snd_addr <= '0;
      bus.grant_id <= '0;
    end else begin
      bus.ack <= '0;
      bus.err <= 1'b0;
      case (state)
        ARB_IDLE: if (valid) begin
          state <= ARB_SEND;
          bus.busy <= 1'b1;
          bus.snd_send <= 1'b1;
          bus.grant_id <= winner;
          bus.snd_addr <= bus.addr_in[winner*ADDR_W +: ADDR_W];
          ptr <= winner;
          timer <= TW'(1);
        end
        ARB_SEND: begin
          timer <= timer + 1'b1;
          // done takes precedence over a simultaneous watchdog expiry
          if (bus.snd_done || timer == TW'(TIMEOUT)) begin
            state <= ARB_GAP;
            bus.snd_send <= 1'b0;
            bus.ack <= bus.snd_done ? NUM_REQ'(1) << bus.grant_id : '0;
            bus.err <= !bus.snd_done;
          end
        end
        ARB_GAP: begin
          state <= ARB_IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule
